menu_text_ram: RTL
==================

Name: menu_text_ram

Overview:
- Parametrised, writable successor to the fixed menu text ROMs. It holds PAGES pages of ROWS x COLS character codes.
- Serves the character renderer through a registered read port, with 1-cycle latency.
- Lets game and menu logic rewrite single characters, for example scores and labels, at run time.
- Clears whole pages with an internal fill state machine.
- Sits between the menu/game control logic and the font/char renderer in the VGA pipeline.

Parameters:
- PAGES, 4, number of text pages; power of 2, at least 2.
- ROWS, 16, text rows per page; power of 2.
- COLS, 16, text columns per page; power of 2.
- CODE_W, 7, character code width.
- SPACE_CODE, SPACE from vga_pkg, fill value written by every clear.
- Derived widths: XY_W = $clog2(ROWS)+$clog2(COLS); PG_W = $clog2(PAGES).

Ports:
- clk  in  1  system pixel clock.
- rst  in  1  synchronous, active-high reset.
- char_xy  in  XY_W  read address {row, col}; row in the upper bits.
- char_code  out  CODE_W  registered character at char_xy on active_page.
- frame_start  in  1  one-cycle pulse at start of frame.
- page_sel  in  PG_W  requested display page.
- active_page  out  PG_W  page currently displayed.
- wr_en  in  1  single-character write strobe.
- wr_page  in  PG_W  write page.
- wr_xy  in  XY_W  write address {row, col}.
- wr_char  in  CODE_W  write data.
- clr_req  in  1  one-cycle request to clear a page.
- clr_page  in  PG_W  page to clear.
- busy  out  1  high while the INIT or CLEAR fill is running.
- done  out  1  one-cycle pulse when a fill completes.
- hl_en  in  1  highlight enable; used only with MENU_TEXT_HIGHLIGHT_EN.
- hl_row  in  $clog2(ROWS)  row to highlight.
- char_inv  out  1  registered highlight flag, aligned with char_code.

Behaviour:
- Reset is synchronous and active-high; all registers below reset on a rising clk edge with rst=1.
- Reset values: char_code=0, active_page=0, done=0, char_inv=0, busy=1, state=INIT, fill counter=0.
- Memory contents are not reset directly; INIT defines them.
- FSM states: INIT, IDLE, CLEAR.
- INIT: writes SPACE_CODE to every location of every page, one per cycle, counter running 0..PAGES*ROWS*COLS-1 with the page taken from the upper counter bits. After the last write: state becomes IDLE, busy=0, and done=1 for one cycle.
- IDLE, clr_req=1: latch clr_page, counter=0, go to CLEAR, busy=1 from the next cycle.
- CLEAR: writes SPACE_CODE to ROWS*COLS locations of the latched page, one per cycle. After the last write: go to IDLE, busy=0, done pulses 1 cycle.
- Exact timing: busy is high for exactly PAGES*ROWS*COLS cycles after INIT and ROWS*COLS cycles for CLEAR. done is asserted on the cycle busy falls.
- clr_req while busy=1 is ignored, not queued.
- rst asserted mid-fill: aborts the fill and restarts INIT from counter 0.
- Write port, IDLE and wr_en=1: the memory at (wr_page, wr_xy) takes wr_char at the clk edge.
- wr_en while busy=1 is dropped and causes no memory change.
- Write and clr_req in the same IDLE cycle: the write is performed first, then CLEAR starts. The clear therefore overwrites the written location if it targets the same page.
- Read: char_code(t+1) = mem[active_page][char_xy](t). Latency is 1 cycle and the output is registered.
- Read and write to the same page and address in the same cycle: read-first, so char_code returns the old data.
- Reads during INIT or CLEAR return the current memory content, either partially cleared or old.
- Page select: active_page <= page_sel only on cycles with frame_start=1; otherwise it holds. This avoids mid-frame tearing.
- page_sel values are always in range, since PAGES is a power of 2.
- Address mapping: row = char_xy[XY_W-1 -: $clog2(ROWS)], col = low $clog2(COLS) bits. With defaults the layout is identical to existing menus: 8-bit char_xy, upper nibble = row.
- Storage must infer block RAM: one write port (shared by the fill FSM and wr_*) and one registered read port.

Optional Feature:
- Macro: MENU_TEXT_HIGHLIGHT_EN.
- Defined: char_inv(t+1) = hl_en(t) && (row of char_xy(t) == hl_row(t)), registered alongside char_code with the same latency. The renderer uses it to swap foreground and background on the selected menu line.
- Undefined: hl_en and hl_row are ignored and char_inv is constant 0.
- Both builds keep identical ports.

Test Plan:
- Reset with default params: hold rst 2 cycles, release. busy stays 1 for exactly 1024 cycles, then done pulses once. Reads at xy 0x00, 0x41 and 0xFF of pages 0-3 all return SPACE_CODE.
- Page switching: write 'D' to page 1, xy 0x41. Set page_sel=1 with no frame_start: active_page stays 0 and reading 0x41 gives SPACE. Pulse frame_start: active_page=1 and the next read of 0x41 returns 'D' one cycle after char_xy is applied.
- Read-during-write: on page 0, xy 0x10, write 'A' while reading 0x10. That cycle's result is SPACE; the next read returns 'A'.
- Clear and dropped writes: fill page 2 with 'W', then clr_req with clr_page=2. busy is high 256 cycles. A wr_en to page 2, xy 0x05 at cycle 10 is dropped, and a second clr_req at cycle 20 is ignored. Afterwards all of page 2 reads SPACE and pages 0/1/3 are unchanged.
- Reset mid-CLEAR: assert rst at CLEAR cycle 100. busy remains 1 and the full 1024-cycle INIT reruns.
- Highlight, built with MENU_TEXT_HIGHLIGHT_EN: hl_en=1, hl_row=4. Reading xy 0x40-0x4F gives char_inv=1; reading 0x3F or 0x50 gives 0. Without the macro, char_inv=0 for all reads.

Source files
------------

// File: rtl/menu_text_ram.sv
// Writable paged character RAM feeding the VGA char renderer, with INIT/CLEAR fill FSM.
// Optional row highlight output enabled by defining MENU_TEXT_HIGHLIGHT_EN.
module menu_text_ram #(
  parameter int PAGES = 4,
  parameter int ROWS = 16,
  parameter int COLS = 16,
  parameter int CODE_W = 7,
  parameter logic [CODE_W-1:0] SPACE_CODE = CODE_W'(32),
  localparam int ROW_W = $clog2(ROWS),
  localparam int COL_W = $clog2(COLS),
  localparam int XY_W = ROW_W + COL_W,
  localparam int PG_W = $clog2(PAGES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XY_W-1:0]   char_xy,
  output logic [CODE_W-1:0] char_code,
  input  logic              frame_start,
  input  logic [PG_W-1:0]   page_sel,
  output logic [PG_W-1:0]   active_page,
  input  logic              wr_en,
  input  logic [PG_W-1:0]   wr_page,
  input  logic [XY_W-1:0]   wr_xy,
  input  logic [CODE_W-1:0] wr_char,
  input  logic              clr_req,
  input  logic [PG_W-1:0]   clr_page,
  output logic              busy,
  output logic              done,
  input  logic              hl_en,
  input  logic [ROW_W-1:0]  hl_row,
  output logic              char_inv
);

  localparam int CELLS_W = PG_W + XY_W;
  localparam int DEPTH = PAGES * ROWS * COLS;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [CELLS_W-1:0]  cnt_r, cnt_s;
  logic [PG_W-1:0]     clr_page_r, clr_page_s;
  logic                busy_s, done_s;
  logic                mem_we_s;
  logic [CELLS_W-1:0]  mem_addr_s;
  logic [CODE_W-1:0]   mem_data_s;
  logic [CODE_W-1:0]   mem [DEPTH];

  // Fill sequencing and the single shared write port (fill has priority over wr_*)
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    clr_page_s = clr_page_r;
    busy_s     = busy;
    done_s     = 1'b0;
    mem_we_s   = 1'b0;
    mem_addr_s = cnt_r;
    mem_data_s = SPACE_CODE;
    case (state_r)
      INIT: begin
        mem_we_s   = 1'b1;
        mem_addr_s = cnt_r;
        if (cnt_r == CELLS_W'(DEPTH - 1)) begin
          state_s = IDLE;
          cnt_s   = {CELLS_W{1'b0}};
          busy_s  = 1'b0;
          done_s  = 1'b1;
        end else begin
          cnt_s = cnt_r + CELLS_W'(1);
        end
      end
      CLEAR: begin
        mem_we_s   = 1'b1;
        mem_addr_s = {clr_page_r, cnt_r[XY_W-1:0]};
        if (cnt_r[XY_W-1:0] == {XY_W{1'b1}}) begin
          state_s = IDLE;
          cnt_s   = {CELLS_W{1'b0}};
          busy_s  = 1'b0;
          done_s  = 1'b1;
        end else begin
          cnt_s = cnt_r + CELLS_W'(1);
        end
      end
      IDLE: begin
        // A same-cycle write lands first; the clear starting next cycle may overwrite it.
        mem_we_s   = wr_en;
        mem_addr_s = {wr_page, wr_xy};
        mem_data_s = wr_char;
        if (clr_req) begin
          state_s    = CLEAR;
          clr_page_s = clr_page;
          cnt_s      = {CELLS_W{1'b0}};
          busy_s     = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = INIT;
        cnt_s   = {CELLS_W{1'b0}};
        busy_s  = 1'b1;
      end
    endcase
  end

  // FSM and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= INIT;
      cnt_r      <= {CELLS_W{1'b0}};
      clr_page_r <= {PG_W{1'b0}};
      busy       <= 1'b1;
      done       <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      clr_page_r <= clr_page_s;
      busy       <= busy_s;
      done       <= done_s;
    end
  end

  // Storage write port
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[mem_addr_s] <= mem_data_s;
    end
  end

  // Registered read-first port on the displayed page
  always_ff @(posedge clk) begin
    if (rst) begin
      char_code <= {CODE_W{1'b0}};
    end else begin
      char_code <= mem[{active_page, char_xy}];
    end
  end

  // Page changes only at frame boundaries to avoid tearing
  always_ff @(posedge clk) begin
    if (rst) begin
      active_page <= {PG_W{1'b0}};
    end else if (frame_start) begin
      active_page <= page_sel;
    end
  end

`ifdef MENU_TEXT_HIGHLIGHT_EN
  // Highlight flag, aligned with char_code
  always_ff @(posedge clk) begin
    if (rst) begin
      char_inv <= 1'b0;
    end else begin
      char_inv <= hl_en && (char_xy[XY_W-1 -: ROW_W] == hl_row);
    end
  end
`else
  logic unused_hl_s;
  assign unused_hl_s = ^{hl_en, hl_row};

  // Highlight disabled: flag held low
  always_ff @(posedge clk) begin
    if (rst) begin
      char_inv <= 1'b0;
    end else begin
      char_inv <= 1'b0;
    end
  end
`endif

endmodule
